warp_scheduler: RTL and testbench

- Per-warp instruction sequencer driving the scheduler side of the execution interface.
- Holds PC, thread mask and active state for up to NUM_WARPS warps.
- Selects the next eligible warp round-robin, fetches its instruction from instruction memory, and issues it to the execution unit.
- Handles launch, kill, flush and EXIT retirement; sits between the kernel launcher/icache and the SIMT execution unit.

---
 rtl/gpu_sched_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/warp_scheduler.sv | 178 +++++++++++++++++
 tb/tb_warp_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_sched_pkg.sv
// Shared types and constants for the warp scheduler.
package gpu_sched_pkg;

  localparam int unsigned CTX_PC_W   = 32;
  localparam int unsigned CTX_MASK_W = 32;

  localparam logic [5:0] EXIT_OPCODE = 6'h3F;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    FETCH_WAIT = 2'd2,
    ISSUE      = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic                  active;
    logic [CTX_PC_W-1:0]   pc;
    logic [CTX_MASK_W-1:0] mask;
  } warp_ctx_t;

  // True when the opcode field marks a warp-terminating instruction.
  function automatic logic is_exit(input logic [5:0] opcode);
    return opcode == EXIT_OPCODE;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N = 8,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             grant_valid
);

  logic [IDX_W-1:0] idx;

  // Scan from ptr upward with wrap; N is a power of two so the add wraps naturally.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptr + IDX_W'(i);
      if (!grant_valid && req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Per-warp instruction sequencer: round-robin select, fetch, issue.
// Optional performance counters are built when SCHED_PERF_CNT_EN is defined.
module warp_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int unsigned NUM_WARPS        = 8,
  parameter int unsigned THREADS_PER_WARP = 32,
  parameter int unsigned WARP_ID_W        = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        launch_valid,
  input  logic [WARP_ID_W-1:0]        launch_warp,
  input  logic [31:0]                 launch_pc,
  input  logic [THREADS_PER_WARP-1:0] launch_mask,
  output logic                        launch_ready,
  input  logic                        kill_valid,
  input  logic [WARP_ID_W-1:0]        kill_warp,
  output logic                        imem_req_valid,
  output logic [31:0]                 imem_req_addr,
  input  logic                        imem_req_ready,
  input  logic                        imem_rsp_valid,
  input  logic [31:0]                 imem_rsp_data,
  output logic [31:0]                 instruction,
  output logic [THREADS_PER_WARP-1:0] thread_mask,
  output logic [WARP_ID_W-1:0]        warp_id,
  output logic                        instruction_valid,
  output logic                        flush,
  output logic [31:0]                 pc,
  input  logic                        ready,
  input  logic                        stall,
  input  logic [31:0]                 next_pc,
  output logic [NUM_WARPS-1:0]        active_warps,
  output logic                        busy
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_issued,
  output logic [31:0]                 perf_stall_cycles,
  output logic [31:0]                 perf_idle_cycles
`endif
);

  localparam int unsigned IDX_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  sched_state_e     state_q, state_d;
  warp_ctx_t        ctx_q [NUM_WARPS];
  logic [IDX_W-1:0] sel_q, rr_q, grant, launch_idx;
  logic [NUM_WARPS-1:0] active_vec, kill_vec, elig;
  logic grant_valid, discard_q;
  logic handshake_c, kill_sel_c, issue_ok_c, exit_c, rsp_take_c, launch_fire_c;
  logic launch_in_range_c;

  // Per-warp active and same-cycle kill decode.
  always_comb begin
    active_vec = '0;
    kill_vec   = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      active_vec[i] = ctx_q[i].active;
      kill_vec[i]   = kill_valid && (kill_warp == WARP_ID_W'(i));
    end
  end

  assign elig = active_vec & ~kill_vec;

  rr_arbiter #(.N(NUM_WARPS)) u_arb (
    .req         (elig),
    .ptr         (rr_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign launch_idx        = launch_warp[IDX_W-1:0];
  assign launch_in_range_c = {1'b0, launch_warp} < (WARP_ID_W+1)'(NUM_WARPS);
  assign launch_ready      = launch_in_range_c && !ctx_q[launch_idx].active
                             && !((state_q != IDLE) && (sel_q == launch_idx))
                             && !(kill_valid && (kill_warp == launch_warp));
  assign launch_fire_c     = launch_valid && launch_ready;

  assign handshake_c = (state_q == ISSUE) && ready && !stall;
  assign kill_sel_c  = kill_valid && (state_q != IDLE) && (kill_warp == WARP_ID_W'(sel_q));
  assign issue_ok_c  = handshake_c && !kill_sel_c;
  assign exit_c      = is_exit(instruction[31:26]);
  assign rsp_take_c  = (state_q == FETCH_WAIT) && imem_rsp_valid && !discard_q;

  assign instruction_valid = (state_q == ISSUE);
  assign imem_req_valid    = (state_q == FETCH);
  assign active_warps      = active_vec;
  assign busy              = (|active_vec) || (state_q != IDLE);

  // Next-state logic; a kill of the held warp always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (grant_valid)    state_d = FETCH;
      FETCH:      if (imem_req_ready) state_d = FETCH_WAIT;
      FETCH_WAIT: if (rsp_take_c)     state_d = ISSUE;
      ISSUE:      if (handshake_c)    state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
    if (kill_sel_c) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Warp contexts: kill beats launch and issue updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_WARPS; i++) ctx_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_WARPS; i++) begin
        if (kill_vec[i]) begin
          ctx_q[i].active <= 1'b0;
        end else if (launch_fire_c && (launch_idx == IDX_W'(i))) begin
          ctx_q[i] <= '{active: 1'b1, pc: launch_pc, mask: CTX_MASK_W'(launch_mask)};
        end else if (issue_ok_c && (sel_q == IDX_W'(i))) begin
          if (exit_c) ctx_q[i].active <= 1'b0;
          else        ctx_q[i].pc     <= next_pc;
        end
      end
    end
  end

  // Selection, fetch address, issue payload, flush and stale-response tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q         <= '0;
      rr_q          <= '0;
      imem_req_addr <= '0;
      instruction   <= '0;
      thread_mask   <= '0;
      warp_id       <= '0;
      pc            <= '0;
      flush         <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      flush <= kill_sel_c;
      if ((state_q == IDLE) && grant_valid) begin
        sel_q         <= grant;
        imem_req_addr <= ctx_q[grant].pc;
      end
      if (rsp_take_c) begin
        instruction <= imem_rsp_data;
        thread_mask <= THREADS_PER_WARP'(ctx_q[sel_q].mask);
        warp_id     <= WARP_ID_W'(sel_q);
        pc          <= imem_req_addr;
      end
      if (issue_ok_c) rr_q <= sel_q + IDX_W'(1);
      if (kill_sel_c && (((state_q == FETCH) && imem_req_ready) ||
                         ((state_q == FETCH_WAIT) && !rsp_take_c)))
        discard_q <= 1'b1;
      else if (imem_rsp_valid && discard_q)
        discard_q <= 1'b0;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  // Saturating issue / stall / idle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued       <= '0;
      perf_stall_cycles <= '0;
      perf_idle_cycles  <= '0;
    end else begin
      if (issue_ok_c && (perf_issued != 32'hFFFF_FFFF))
        perf_issued <= perf_issued + 32'd1;
      if ((state_q == ISSUE) && (stall || !ready) && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if ((state_q == IDLE) && !grant_valid && (perf_idle_cycles != 32'hFFFF_FFFF))
        perf_idle_cycles <= perf_idle_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Scenario bench for warp_scheduler with a scoreboard of expected issues.
module tb_warp_scheduler;

  logic        clk, rst_n;
  logic        launch_valid, launch_ready, kill_valid;
  logic [5:0]  launch_warp, kill_warp, warp_id;
  logic [31:0] launch_pc, launch_mask;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic [31:0] instruction, thread_mask, pc, next_pc;
  logic        instruction_valid, flush, ready, stall, busy;
  logic [7:0]  active_warps;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_issued, perf_stall_cycles, perf_idle_cycles;
`endif

  typedef struct packed {
    logic [5:0]  wid;
    logic [31:0] pc;
    logic [31:0] mask;
    logic [31:0] instr;
  } iss_t;

  iss_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_issued = 0;
  int   rsp_lat  = 1;

  warp_scheduler #(.NUM_WARPS(8), .THREADS_PER_WARP(32), .WARP_ID_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .launch_valid(launch_valid), .launch_warp(launch_warp), .launch_pc(launch_pc),
    .launch_mask(launch_mask), .launch_ready(launch_ready),
    .kill_valid(kill_valid), .kill_warp(kill_warp),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .instruction(instruction), .thread_mask(thread_mask), .warp_id(warp_id),
    .instruction_valid(instruction_valid), .flush(flush), .pc(pc),
    .ready(ready), .stall(stall), .next_pc(next_pc),
    .active_warps(active_warps), .busy(busy)
`ifdef SCHED_PERF_CNT_EN
    , .perf_issued(perf_issued), .perf_stall_cycles(perf_stall_cycles),
    .perf_idle_cycles(perf_idle_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: low byte 0x0C holds EXIT, else a tagged word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[7:0] == 8'h0C) return 32'hFC00_0000;
    return {6'h01, a[25:0]};
  endfunction

  // Instruction memory: always accepts, answers rsp_lat cycles after accept.
  initial begin
    logic [31:0] a;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        a = imem_req_addr;
        repeat (rsp_lat) @(posedge clk);
        #1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(a);
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Execution unit resumes each warp at the following word.
  initial begin
    next_pc = '0;
    forever begin
      @(negedge clk);
      next_pc = pc + 32'd4;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_exp(input logic [5:0] w, input logic [31:0] p, input logic [31:0] m);
    sb.push_back({w, p, m, mem_word(p)});
  endtask

  task automatic drive_launch(input logic [5:0] w, input logic [31:0] p, input logic [31:0] m);
    launch_valid = 1'b1;
    launch_warp  = w;
    launch_pc    = p;
    launch_mask  = m;
  endtask

  // Waits (bounded) for an issue handshake and returns the issued payload.
  task automatic wait_issue(output logic ok, output iss_t got);
    ok  = 1'b0;
    got = '0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (instruction_valid && ready && !stall) begin
        got = {warp_id, pc, thread_mask, instruction};
        ok  = 1'b1;
        n_issued++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; launch_valid = 1'b0; launch_warp = '0; launch_pc = '0; launch_mask = '0;
    kill_valid = 1'b0; kill_warp = '0; ready = 1'b1; stall = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({instruction_valid, imem_req_valid, flush, busy} !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ctrl%0d: got %b expected 0000", k,
                           {instruction_valid, imem_req_valid, flush, busy});
      end
      n_checks++;
      if ({instruction, thread_mask, warp_id, pc, imem_req_addr} !== 134'h0) begin
        n_fail++; $display("FAIL reset_data%0d: got %h expected 0", k,
                           {instruction, thread_mask, warp_id, pc, imem_req_addr});
      end
      n_checks++;
      if (active_warps !== 8'h00) begin
        n_fail++; $display("FAIL reset_active%0d: got %h expected 00", k, active_warps);
      end
      n_checks++;
      if (launch_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_launch_ready%0d: got %b expected 1", k, launch_ready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    end
  endtask

  task automatic test_single_warp();
    iss_t got, exp;
    logic ok;
    for (int k = 0; k < 4; k++) push_exp(6'd0, 32'h100 + 32'(4 * k), 32'hFFFF_FFFF);
    drive_launch(6'd0, 32'h100, 32'hFFFF_FFFF);
    @(negedge clk);
    n_checks++;
    if (launch_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_launch_ready: got %b expected 1", launch_ready);
    end
    @(posedge clk); #1; launch_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_issue(ok, got);
      exp = sb.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin
        n_fail++; $display("FAIL single_issue%0d: got %h expected %h timeout=%0b", k, got, exp, !ok);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({busy, active_warps} !== 9'h000) begin
      n_fail++; $display("FAIL single_done: got %h expected 000", {busy, active_warps});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    iss_t got, exp;
    logic ok;
    logic [31:0] masks [3];
    masks[0] = 32'h0000_FFFF; masks[1] = 32'hFFFF_0000; masks[2] = 32'h1234_5678;
    for (int r = 0; r < 3; r++)
      for (int w = 0; w < 3; w++)
        push_exp(6'(w), 32'h1004 + 32'(w * 32'h1000) + 32'(4 * r), masks[w]);
    for (int w = 0; w < 3; w++) begin
      drive_launch(6'(w), 32'h1004 + 32'(w * 32'h1000), masks[w]);
      @(negedge clk);
      n_checks++;
      if (launch_ready !== 1'b1) begin
        n_fail++; $display("FAIL rr_launch_ready%0d: got %b expected 1", w, launch_ready);
      end
      @(posedge clk); #1;
    end
    launch_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      wait_issue(ok, got);
      exp = sb.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin
        n_fail++; $display("FAIL rr_issue%0d: got %h expected %h timeout=%0b", k, got, exp, !ok);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({busy, active_warps} !== 9'h000) begin
      n_fail++; $display("FAIL rr_done: got %h expected 000", {busy, active_warps});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    iss_t got, exp;
    logic ok, found;
    push_exp(6'd4, 32'h4008, 32'hA5A5_A5A5);
    push_exp(6'd4, 32'h400C, 32'hA5A5_A5A5);
    stall = 1'b1;
    drive_launch(6'd4, 32'h4008, 32'hA5A5_A5A5);
    @(posedge clk); #1; launch_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (instruction_valid) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL stall_reach_issue: got timeout expected instruction_valid");
    end
    exp = sb[0];
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if ({instruction_valid, warp_id, pc, instruction} !== {1'b1, exp.wid, exp.pc, exp.instr}) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h expected %h", k,
                           {instruction_valid, warp_id, pc, instruction},
                           {1'b1, exp.wid, exp.pc, exp.instr});
      end
    end
    @(posedge clk); #1; stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_issue(ok, got);
      exp = sb.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin
        n_fail++; $display("FAIL stall_issue%0d: got %h expected %h timeout=%0b", k, got, exp, !ok);
      end
    end
`ifdef SCHED_PERF_CNT_EN
    n_checks++;
    if (perf_stall_cycles !== 32'd5) begin
      n_fail++; $display("FAIL perf_stall: got %0d expected 5", perf_stall_cycles);
    end
`endif
  endtask

  task automatic test_exit();
    iss_t got, exp;
    logic ok;
    push_exp(6'd3, 32'h500C, 32'h0000_00FF);
    drive_launch(6'd3, 32'h500C, 32'h0000_00FF);
    @(posedge clk); #1; launch_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (active_warps !== 8'h08) begin
      n_fail++; $display("FAIL exit_launched: got %h expected 08", active_warps);
    end
    wait_issue(ok, got);
    exp = sb.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin
      n_fail++; $display("FAIL exit_issue: got %h expected %h timeout=%0b", got, exp, !ok);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, active_warps} !== 9'h000) begin
      n_fail++; $display("FAIL exit_retired: got %h expected 000", {busy, active_warps});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_kill_fetch_wait();
    logic found, seen;
    rsp_lat = 4;
    drive_launch(6'd1, 32'h6000, 32'hFFFF_FFFF);
    @(posedge clk); #1; launch_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (imem_req_valid) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL kill_reach_fetch: got timeout expected imem_req_valid");
    end
    @(posedge clk); #1;
    kill_valid = 1'b1; kill_warp = 6'd1;
    @(posedge clk); #1;
    kill_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({flush, instruction_valid, active_warps[1]} !== 3'b100) begin
      n_fail++; $display("FAIL kill_flush: got %b expected 100", {flush, instruction_valid, active_warps[1]});
    end
    @(negedge clk);
    n_checks++;
    if (flush !== 1'b0) begin
      n_fail++; $display("FAIL kill_flush_pulse: got %b expected 0", flush);
    end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (instruction_valid || imem_req_valid || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL kill_quiet: got activity=%b expected 0", seen);
    end
    rsp_lat = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_launch_kill_and_back_to_back();
    iss_t got, exp;
    logic ok;
    drive_launch(6'd2, 32'h8000, 32'hFFFF_FFFF);
    @(negedge clk);
    n_checks++;
    if (launch_ready !== 1'b1) begin
      n_fail++; $display("FAIL lk_ready_nokill: got %b expected 1", launch_ready);
    end
    launch_valid = 1'b0;
    @(posedge clk); #1;
    drive_launch(6'd2, 32'h8000, 32'hFFFF_FFFF);
    kill_valid = 1'b1; kill_warp = 6'd2;
    @(negedge clk);
    n_checks++;
    if (launch_ready !== 1'b0) begin
      n_fail++; $display("FAIL lk_ready_kill: got %b expected 0", launch_ready);
    end
    @(posedge clk); #1;
    kill_valid = 1'b0;
    launch_warp = 6'd8;
    @(negedge clk);
    n_checks++;
    if ({launch_ready, busy, active_warps} !== 10'h000) begin
      n_fail++; $display("FAIL lk_inactive_and_range: got %h expected 000", {launch_ready, busy, active_warps});
    end
    @(posedge clk); #1; launch_valid = 1'b0;
    for (int k = 0; k < 3; k++) push_exp(6'd5, 32'h7004 + 32'(4 * k), 32'h0F0F_0F0F);
    drive_launch(6'd5, 32'h7004, 32'h0F0F_0F0F);
    @(posedge clk); #1; launch_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_issue(ok, got);
      exp = sb.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin
        n_fail++; $display("FAIL b2b_issue%0d: got %h expected %h timeout=%0b", k, got, exp, !ok);
      end
    end
`ifdef SCHED_PERF_CNT_EN
    n_checks++;
    if (perf_issued !== 32'(n_issued)) begin
      n_fail++; $display("FAIL perf_issued: got %0d expected %0d", perf_issued, n_issued);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_warp();
    test_round_robin();
    test_stall();
    test_exit();
    test_kill_fetch_wait();
    test_launch_kill_and_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
